// File: rtl/mult8_pkg.sv
// rtl/mult8_pkg.sv - shared types and widths for the two-requester 8x8 multiplier
package mult8_pkg;
    localparam int OP_W   = 8;
    localparam int NIB_W  = 4;
    localparam int PROD_W = 16;
    localparam int STEPS  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mul4x4.sv
// rtl/mul4x4.sv - combinational 4x4 unsigned array multiplier
module mul4x4
    import mult8_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    output logic [2*NIB_W-1:0] p
);
    always_comb begin
        p = '0;
        // One shifted row of a per set bit of b.
        for (int i = 0; i < NIB_W; i++) begin
            if (b[i]) begin
                p = p + ({{NIB_W{1'b0}}, a} << i);
            end
        end
    end
endmodule

// File: rtl/mult8_sched.sv
// rtl/mult8_sched.sv - round-robin two-requester 8x8 multiplier using one 4x4 multiplier over four steps
module mult8_sched
    import mult8_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_a0,
    input  logic [OP_W-1:0]   req_b0,
    input  logic [OP_W-1:0]   req_a1,
    input  logic [OP_W-1:0]   req_b1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [PROD_W-1:0] rsp_product,
    output logic              busy
);
    state_t              state;
    logic [1:0]          k;
    logic [PROD_W-1:0]   acc;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic                id_q;
    logic                lp;

    logic                grant;
    logic                accept;
    logic [NIB_W-1:0]    nib_a;
    logic [NIB_W-1:0]    nib_b;
    logic [2*NIB_W-1:0]  pp;
    logic [PROD_W-1:0]   pp_shifted;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant     = (req_valid == 2'b11) ? ~lp : req_valid[1];
        req_ready = 2'b00;
        if (state == IDLE && req_valid != 2'b00) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
        accept = |(req_valid & req_ready);
    end

    // k[0] selects the high nibble of a, k[1] the high nibble of b.
    always_comb begin
        nib_a = k[0] ? a_q[7:4] : a_q[3:0];
        nib_b = k[1] ? b_q[7:4] : b_q[3:0];
        case (k)
            2'd0:    pp_shifted = {8'd0, pp};
            2'd3:    pp_shifted = {pp, 8'd0};
            default: pp_shifted = {4'd0, pp, 4'd0};
        endcase
    end

    mul4x4 u_mul (
        .a (nib_a),
        .b (nib_b),
        .p (pp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= 2'd0;
            acc   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= 1'b0;
            lp    <= RR_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= grant ? req_a1 : req_a0;
                        b_q   <= grant ? req_b1 : req_b0;
                        id_q  <= grant;
                        lp    <= grant;
                        acc   <= '0;
                        k     <= 2'd0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc + pp_shifted;
                    k   <= k + 2'd1;
                    if (k == 2'(STEPS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = (state == DONE);
    assign rsp_product = (state == DONE) ? acc : '0;
    assign rsp_id      = id_q;
    assign busy        = (state != IDLE);
endmodule

// File: tb/tb_mult8_sched.sv
// tb/tb_mult8_sched.sv - self-checking bench for mult8_sched
module tb_mult8_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [7:0]  req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [15:0] rsp_product;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit lp_m = 1'b0;

    always #5 clk = ~clk;

    mult8_sched #(.RR_INIT(1'b0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: single requester wins, a tie goes to the one not served last.
    function automatic bit pick(input logic [1:0] v);
        if (v == 2'b11) return !lp_m;
        return v[1];
    endfunction

    task automatic run_job(input logic [1:0] pre, input logic [1:0] v,
                           input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1, input int hold);
        bit          g;
        logic [15:0] expp;
        int          lat;
        @(negedge clk);
        req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
        rsp_ready = 1'b0;
        if (pre != 2'b00) begin
            req_valid = pre;
            #1;
            chk("pre_grant", req_ready, pick(pre) ? 2'b10 : 2'b01);
        end
        req_valid = v;
        #1;
        g    = pick(v);
        expp = g ? 16'(a1) * 16'(b1) : 16'(a0) * 16'(b0);
        chk("grant", req_ready, g ? 2'b10 : 2'b01);
        @(posedge clk);
        lp_m = g;
        #1;
        req_a0 = 8'($urandom); req_b0 = 8'($urandom);
        req_a1 = 8'($urandom); req_b1 = 8'($urandom);
        req_valid = 2'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rsp_valid) begin
                chk("mul_quiet", {busy, req_ready, rsp_product}, {1'b1, 2'b00, 16'h0000});
            end
        end while (!rsp_valid && lat < 20);
        chk("latency", lat, 5);
        chk("product", rsp_product, expp);
        chk("rsp_id", rsp_id, g);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold", {rsp_valid, busy, req_ready, rsp_id, rsp_product},
                {1'b1, 1'b1, 2'b00, g, expp});
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_hs", {rsp_valid, busy, rsp_product}, {1'b0, 1'b0, 16'h0000});
    endtask

    initial begin
        int seen;
        logic [1:0] rv;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {rsp_valid, busy, rsp_id, rsp_product}, 19'h0);
        chk("rst_ready_idle", req_ready, 2'b00);
        req_valid = 2'b11;
        #1;
        chk("rst_ready_tie", req_ready, 2'b10);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Both held high from reset: order 1, 0, 1.
        run_job(2'b00, 2'b11, 8'h0A, 8'h0B, 8'h12, 8'h34, 0);
        run_job(2'b00, 2'b11, 8'h0A, 8'h0B, 8'h12, 8'h34, 0);
        run_job(2'b00, 2'b11, 8'h0A, 8'h0B, 8'h12, 8'h34, 0);

        run_job(2'b00, 2'b01, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
        run_job(2'b00, 2'b10, 8'h33, 8'h44, 8'hE7, 8'h9D, 10);
        run_job(2'b00, 2'b01, 8'h00, 8'hC7, 8'h11, 8'h11, 1);
        run_job(2'b00, 2'b10, 8'h11, 8'h11, 8'h80, 8'h02, 0);
        // Requester withdraws before the accept edge.
        run_job(2'b11, 2'b01, 8'h21, 8'h43, 8'h65, 8'h87, 0);

        // Reset during MUL step k=2 drops the in-flight job.
        @(negedge clk);
        req_valid = 2'b10; req_a1 = 8'h5A; req_b1 = 8'hC3;
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {rsp_valid, busy, rsp_id, rsp_product}, 19'h0);
        @(negedge clk);
        rst_n = 1'b1;
        lp_m = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        chk("no_orphan_rsp", seen, 0);
        run_job(2'b00, 2'b11, 8'h0C, 8'h0D, 8'hAB, 8'hCD, 0);

        for (int i = 0; i < 10; i++) begin
            rv = 2'($urandom_range(1, 3));
            run_job(2'b00, rv, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
